// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
module seq_alu #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1,
    parameter int CTRL_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  data1_i,
    input  logic [WIDTH-1:0]  data2_i,
    input  logic [CTRL_W-1:0] ALUCtrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              Zero_o
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] ALU_XOR = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] ALU_SLL = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] ALU_MUL = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] ALU_SRA = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] ALU_SRL = CTRL_W'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_sum;
    logic [SH_W-1:0]  shamt;

    assign ready_o = (state == IDLE);
    assign shamt   = data2_i[SH_W-1:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            ALU_AND: alu_res = data1_i & data2_i;
            ALU_XOR: alu_res = data1_i ^ data2_i;
            ALU_SLL: alu_res = data1_i << shamt;
            ALU_ADD: alu_res = data1_i + data2_i;
            ALU_SUB: alu_res = data1_i - data2_i;
            ALU_SRA: alu_res = WIDTH'($signed(data1_i) >>> shamt);
            ALU_SRL: alu_res = data1_i >> shamt;
            default: alu_res = '0;
        endcase
    end

    // Partial products of the low MUL_BITS multiplier bits folded into the accumulator.
    always_comb begin
        mul_sum = acc;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier[i]) mul_sum = mul_sum + (mcand << i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            data_o  <= '0;
            Zero_o  <= 1'b1;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        if (ALUCtrl_i == ALU_MUL) begin
                            mcand  <= data1_i;
                            mplier <= data2_i;
                            acc    <= '0;
                            cnt    <= CNT_W'(STEPS);
                            state  <= MUL;
                        end else begin
                            data_o  <= alu_res;
                            Zero_o  <= (alu_res == '0);
                            valid_o <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= mul_sum;
                    mplier <= mplier >> MUL_BITS;
                    mcand  <= mcand << MUL_BITS;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        data_o  <= mul_sum;
                        Zero_o  <= (mul_sum == '0);
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: three configurations checked every cycle against a transaction-level
// model, plus directed vectors with hand-computed results and latencies.
module tb_seq_alu;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_XOR = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;

    localparam int W_K  [3] = '{32, 32, 16};
    localparam int MB_K [3] = '{1, 4, 2};

    logic        clk;
    logic        rst_n;
    logic        valid_i [3];
    logic        ready_i [3];
    logic [31:0] a       [3];
    logic [31:0] b       [3];
    logic [3:0]  ctrl    [3];

    logic        rdy0, rdy1, rdy2, vo0, vo1, vo2, z0, z1, z2;
    logic [31:0] d0, d1;
    logic [15:0] d2;
    logic [31:0] dout [3];
    logic        vo   [3];
    logic        rdy  [3];
    logic        zo   [3];

    assign dout[0] = d0;
    assign dout[1] = d1;
    assign dout[2] = {16'h0, d2};
    assign vo[0] = vo0;
    assign vo[1] = vo1;
    assign vo[2] = vo2;
    assign rdy[0] = rdy0;
    assign rdy[1] = rdy1;
    assign rdy[2] = rdy2;
    assign zo[0] = z0;
    assign zo[1] = z1;
    assign zo[2] = z2;

    seq_alu #(.WIDTH(32), .MUL_BITS(1), .CTRL_W(3)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i[0]), .ready_o(rdy0),
        .data1_i(a[0]), .data2_i(b[0]), .ALUCtrl_i(ctrl[0][2:0]),
        .valid_o(vo0), .ready_i(ready_i[0]), .data_o(d0), .Zero_o(z0)
    );

    seq_alu #(.WIDTH(32), .MUL_BITS(4), .CTRL_W(3)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i[1]), .ready_o(rdy1),
        .data1_i(a[1]), .data2_i(b[1]), .ALUCtrl_i(ctrl[1][2:0]),
        .valid_o(vo1), .ready_i(ready_i[1]), .data_o(d1), .Zero_o(z1)
    );

    seq_alu #(.WIDTH(16), .MUL_BITS(2), .CTRL_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i[2]), .ready_o(rdy2),
        .data1_i(a[2][15:0]), .data2_i(b[2][15:0]), .ALUCtrl_i(ctrl[2]),
        .valid_o(vo2), .ready_i(ready_i[2]), .data_o(d2), .Zero_o(z2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference on w-bit operands using plain 64-bit integer math.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input int w);
        longint unsigned mask, ux, uy, r;
        longint          sx;
        int              sh;
        mask = (64'd1 << w) - 64'd1;
        ux   = {32'h0, x} & mask;
        uy   = {32'h0, y} & mask;
        sh   = int'(uy % longint'(w));
        sx   = ux[w-1] ? longint'(ux | ~mask) : longint'(ux);
        case (op)
            OP_AND:  r = ux & uy;
            OP_XOR:  r = ux ^ uy;
            OP_SLL:  r = ux << sh;
            OP_ADD:  r = ux + uy;
            OP_SUB:  r = ux - uy;
            OP_MUL:  r = ux * uy;
            OP_SRA:  r = longint'(sx >>> sh);
            OP_SRL:  r = ux >> sh;
            default: r = 64'd0;
        endcase
        return 32'(r & mask);
    endfunction

    // Transaction model: idle -> (MUL: WIDTH/MUL_BITS busy cycles) -> result held until ready_i.
    bit          m_busy  [3];
    bit          m_valid [3];
    int          m_cnt   [3];
    logic [31:0] m_res   [3];
    logic [31:0] m_data  [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k]  <= 1'b0;
                m_valid[k] <= 1'b0;
                m_cnt[k]   <= 0;
                m_res[k]   <= '0;
                m_data[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_valid[k]) begin
                    if (ready_i[k]) m_valid[k] <= 1'b0;
                end else if (m_busy[k]) begin
                    m_cnt[k] <= m_cnt[k] - 1;
                    if (m_cnt[k] == 1) begin
                        m_busy[k]  <= 1'b0;
                        m_valid[k] <= 1'b1;
                        m_data[k]  <= m_res[k];
                    end
                end else if (valid_i[k]) begin
                    if (ctrl[k] == OP_MUL) begin
                        m_busy[k] <= 1'b1;
                        m_cnt[k]  <= W_K[k] / MB_K[k];
                        m_res[k]  <= ref_alu(ctrl[k], a[k], b[k], W_K[k]);
                    end else begin
                        m_valid[k] <= 1'b1;
                        m_data[k]  <= ref_alu(ctrl[k], a[k], b[k], W_K[k]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("dut%0d valid_o", k), {31'h0, vo[k]}, {31'h0, m_valid[k]});
                check($sformatf("dut%0d ready_o", k), {31'h0, rdy[k]},
                      {31'h0, !(m_busy[k] || m_valid[k])});
                check($sformatf("dut%0d data_o", k), dout[k], m_data[k]);
                check($sformatf("dut%0d Zero_o", k), {31'h0, zo[k]}, {31'h0, m_data[k] == 32'h0});
            end
        end
    end

    // One request; lat_exp counts clock edges after the accept edge before valid_o appears.
    task automatic do_op(input int k, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat_exp,
                         input string name);
        int lat;
        @(negedge clk);
        valid_i[k] = 1'b1;
        ctrl[k]    = op;
        a[k]       = x;
        b[k]       = y;
        @(negedge clk);
        valid_i[k] = 1'b0;
        ctrl[k]    = OP_AND;
        a[k]       = 32'hDEAD_BEEF;
        b[k]       = ~y;
        lat = 0;
        while (!vo[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(lat_exp));
        check({name, " data"}, dout[k], exp);
        check({name, " zero"}, {31'h0, zo[k]}, {31'h0, exp == 32'h0});
    endtask

    initial begin
        bit seen;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid_i[k] = 1'b0;
            ready_i[k] = 1'b1;
            a[k]       = '0;
            b[k]       = '0;
            ctrl[k]    = '0;
        end
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset valid_o", {31'h0, vo[0]}, 32'h0);
        check("reset ready_o", {31'h0, rdy[0]}, 32'h1);
        check("reset data_o", dout[0], 32'h0);
        check("reset Zero_o", {31'h0, zo[0]}, 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        do_op(0, OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 0,  "add wrap");
        do_op(0, OP_SUB, 32'h5,         32'h7,         32'hFFFF_FFFE, 0,  "sub wrap");
        do_op(0, OP_SRA, 32'h8000_0000, 32'h24,        32'hF800_0000, 0,  "sra");
        do_op(0, OP_SRL, 32'h8000_0000, 32'h24,        32'h0800_0000, 0,  "srl");
        do_op(0, OP_SLL, 32'h1,         32'd31,        32'h8000_0000, 0,  "sll");
        do_op(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0,  "and");
        do_op(0, OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0,  "xor");
        do_op(0, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 32, "mul x1");
        do_op(0, OP_MUL, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 32, "mul neg");
        do_op(0, OP_MUL, 32'h0,         32'h1_2345,    32'h0,         32, "mul zero");
        do_op(1, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 8,  "mul x4");
        do_op(1, OP_ADD, 32'h3,         32'h4,         32'h7,         0,  "add x4");
        do_op(2, OP_ADD, 32'hFFFF,      32'h2,         32'h0001,      0,  "add w16");
        do_op(2, 4'hA,   32'h1234,      32'h5,         32'h0,         0,  "illegal w16");
        do_op(2, OP_MUL, 32'h0123,      32'h0456,      32'hEDC2,      8,  "mul w16");
        do_op(2, OP_SRA, 32'h8000,      32'h13,        32'hF000,      0,  "sra w16");

        // Backpressure: result must hold while valid_i pulses are ignored.
        ready_i[0] = 1'b0;
        do_op(0, OP_ADD, 32'h10, 32'h20, 32'h30, 0, "bp add");
        for (int c = 0; c < 10; c++) begin
            valid_i[0] = c[0];
            ctrl[0]    = OP_SUB;
            a[0]       = 32'(c);
            @(negedge clk);
            check("bp valid held", {31'h0, vo[0]}, 32'h1);
            check("bp data held", dout[0], 32'h30);
        end
        valid_i[0] = 1'b0;
        ready_i[0] = 1'b1;
        @(negedge clk);
        check("bp release valid", {31'h0, vo[0]}, 32'h0);
        check("bp release ready", {31'h0, rdy[0]}, 32'h1);
        check("bp data kept", dout[0], 32'h30);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (vo[0]) seen = 1'b1;
        end
        check("bp no second result", {31'h0, seen}, 32'h0);

        // Reset in cycle 5 of a 32-cycle MUL: cleared at once, no stale result later.
        @(negedge clk);
        valid_i[0] = 1'b1;
        ctrl[0]    = OP_MUL;
        a[0]       = 32'h1234_5678;
        b[0]       = 32'h9ABC_DEF0;
        @(negedge clk);
        valid_i[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid-mul busy", {31'h0, rdy[0]}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid_o", {31'h0, vo[0]}, 32'h0);
        check("async rst ready_o", {31'h0, rdy[0]}, 32'h1);
        check("async rst data_o", dout[0], 32'h0);
        check("async rst Zero_o", {31'h0, zo[0]}, 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vo[0]) seen = 1'b1;
        end
        check("no stale valid after reset", {31'h0, seen}, 32'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
